// File: rtl/am2940_pkg.sv
// Shared encodings for the word-count controller: counting modes and FSM states.
package am2940_pkg;

  localparam logic [1:0] WC_DOWN = 2'b00;
  localparam logic [1:0] WC_UP   = 2'b01;
  localparam logic [1:0] WC_RSVD = 2'b10;
  localparam logic [1:0] WC_FREE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/wc_done_cmp.sv
// Combinational terminal-count detector: flags the cnt pulse that completes the block.
module wc_done_cmp
  import am2940_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       cr,
  input  logic [WIDTH-1:0] wc,
  input  logic [WIDTH-1:0] wr,
  input  logic             cnt,
  output logic             terminal
);

  logic [WIDTH-1:0] wc_inc;
  logic [WIDTH-1:0] one;

  assign one    = WIDTH'(1);
  assign wc_inc = wc + one;

  // Modulo compare makes a loaded 0 mean a full 2^WIDTH-word block in both modes.
  always_comb begin
    terminal = 1'b0;
    if (cnt) begin
      case (cr)
        WC_DOWN: terminal = (wc == one);
        WC_UP:   terminal = (wc_inc == wr);
        default: terminal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/word_count_ctl.sv
// Word-count controller FSM (IDLE/RUN/DONE) with word register and counter.
// Define WC_OVERRUN_ERR_EN to build the sticky overrun flag (cnt seen while DONE).
module word_count_ctl
  import am2940_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] di,
  input  logic [1:0]       cr,
  input  logic             ldwr,
  input  logic             reinit,
  input  logic             cnt,
  output logic [WIDTH-1:0] wc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state_dbg
);

  state_t           state;
  logic [WIDTH-1:0] wr;
  logic             terminal;
  logic [WIDTH-1:0] one;

  assign one = WIDTH'(1);

  wc_done_cmp #(.WIDTH(WIDTH)) u_done_cmp (
    .cr       (cr),
    .wc       (wc),
    .wr       (wr),
    .cnt      (cnt),
    .terminal (terminal)
  );

  // Priority rst > ldwr > reinit > cnt; a cnt alongside a load is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      wc    <= '0;
      wr    <= '0;
    end else if (ldwr) begin
      wr    <= di;
      wc    <= (cr == WC_UP) ? '0 : di;
      state <= ST_RUN;
    end else if (reinit) begin
      wc    <= (cr == WC_UP) ? '0 : wr;
      state <= ST_RUN;
    end else if (cnt && state == ST_RUN) begin
      case (cr)
        WC_DOWN: wc <= wc - one;
        WC_UP:   wc <= wc + one;
        WC_FREE: wc <= wc - one;
        default: wc <= wc;
      endcase
      if (terminal) state <= ST_DONE;
    end
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

`ifdef WC_OVERRUN_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst || ldwr || reinit) begin
      err_q <= 1'b0;
    end else if (cnt && state == ST_DONE) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_word_count_ctl.sv
// Scoreboard bench for word_count_ctl: driver pushes hand-computed expectations, monitor pops and compares.
module tb_word_count_ctl;

  localparam int W = 8;
`ifdef WC_OVERRUN_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  // Expected word: {state, err, done, busy, wc}
  localparam int EW = W + 5;

  logic         clk;
  logic         rst;
  logic [W-1:0] di;
  logic [1:0]   cr;
  logic         ldwr;
  logic         reinit;
  logic         cnt;
  logic [W-1:0] wc;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   state_dbg;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks;
  int            errors;

  word_count_ctl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .di        (di),
    .cr        (cr),
    .ldwr      (ldwr),
    .reinit    (reinit),
    .cnt       (cnt),
    .wc        (wc),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1; di = '0; cr = 2'b00; ldwr = 1'b0; reinit = 1'b0; cnt = 1'b0;
  end

  // Driver: apply one cycle of inputs and queue the state expected after that edge.
  task automatic drive(input string nm, input logic r, input logic [1:0] c, input logic [W-1:0] d,
                       input logic l, input logic ri, input logic n,
                       input logic [W-1:0] e_wc, input logic [1:0] e_st, input logic e_err);
    logic e_busy;
    logic e_done;
    @(negedge clk);
    rst = r; cr = c; di = d; ldwr = l; reinit = ri; cnt = n;
    e_busy = (e_st == S_RUN);
    e_done = (e_st == S_DONE);
    exp_q.push_back({e_st, e_err, e_done, e_busy, e_wc});
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] exp_v;
      logic [EW-1:0] act_v;
      string         nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {state_dbg, err, done, busy, wc};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got state=%0d err=%b done=%b busy=%b wc=%h, want state=%0d err=%b done=%b busy=%b wc=%h",
                 nm, act_v[EW-1 -: 2], act_v[W+2], act_v[W+1], act_v[W], act_v[W-1:0],
                 exp_v[EW-1 -: 2], exp_v[W+2], exp_v[W+1], exp_v[W], exp_v[W-1:0]);
      end
    end
  end

  initial begin
    int drain;
    drive("reset",        1, 2'b00, 8'h00, 0, 0, 0, 8'h00, S_IDLE, 0);
    drive("cnt_idle",     0, 2'b00, 8'h00, 0, 0, 1, 8'h00, S_IDLE, 0);
    // Down count from 3
    drive("ld_down3",     0, 2'b00, 8'h03, 1, 0, 0, 8'h03, S_RUN,  0);
    drive("down_2",       0, 2'b00, 8'h00, 0, 0, 1, 8'h02, S_RUN,  0);
    drive("down_1",       0, 2'b00, 8'h00, 0, 0, 1, 8'h01, S_RUN,  0);
    drive("down_done",    0, 2'b00, 8'h00, 0, 0, 1, 8'h00, S_DONE, 0);
    drive("overrun_dn",   0, 2'b00, 8'h00, 0, 0, 1, 8'h00, S_DONE, ERR_EN);
    drive("reinit_down",  0, 2'b00, 8'h00, 0, 1, 0, 8'h03, S_RUN,  0);
    drive("hold_run",     0, 2'b00, 8'h00, 0, 0, 0, 8'h03, S_RUN,  0);
    // Up count to 4
    drive("ld_up4",       0, 2'b01, 8'h04, 1, 0, 0, 8'h00, S_RUN,  0);
    drive("up_1",         0, 2'b01, 8'h00, 0, 0, 1, 8'h01, S_RUN,  0);
    drive("up_2",         0, 2'b01, 8'h00, 0, 0, 1, 8'h02, S_RUN,  0);
    drive("up_3",         0, 2'b01, 8'h00, 0, 0, 1, 8'h03, S_RUN,  0);
    drive("up_done",      0, 2'b01, 8'h00, 0, 0, 1, 8'h04, S_DONE, 0);
    drive("up_fifth",     0, 2'b01, 8'h00, 0, 0, 1, 8'h04, S_DONE, ERR_EN);
    drive("reinit_up",    0, 2'b01, 8'h00, 0, 1, 0, 8'h00, S_RUN,  0);
    drive("up_again_1",   0, 2'b01, 8'h00, 0, 0, 1, 8'h01, S_RUN,  0);
    // ldwr wins over a coincident cnt
    drive("ld_with_cnt",  0, 2'b00, 8'h10, 1, 0, 1, 8'h10, S_RUN,  0);
    drive("ri_with_cnt",  0, 2'b00, 8'h00, 0, 1, 1, 8'h10, S_RUN,  0);
    // Free-run wraps through zero
    drive("ld_free0",     0, 2'b11, 8'h00, 1, 0, 0, 8'h00, S_RUN,  0);
    drive("free_ff",      0, 2'b11, 8'h00, 0, 0, 1, 8'hFF, S_RUN,  0);
    drive("free_fe",      0, 2'b11, 8'h00, 0, 0, 1, 8'hFE, S_RUN,  0);
    drive("rsvd_hold",    0, 2'b10, 8'h00, 0, 0, 1, 8'hFE, S_RUN,  0);
    // Mode switch in RUN takes effect on next cnt without reload
    drive("switch_up",    0, 2'b01, 8'h00, 0, 0, 1, 8'hFF, S_RUN,  0);
    // Reset mid-RUN wins over ldwr and cnt
    drive("ld_down5",     0, 2'b00, 8'h05, 1, 0, 0, 8'h05, S_RUN,  0);
    drive("rst_midrun",   1, 2'b00, 8'h33, 1, 0, 1, 8'h00, S_IDLE, 0);
    drive("cnt_after_rst",0, 2'b00, 8'h00, 0, 0, 1, 8'h00, S_IDLE, 0);
    // Overrun then ldwr clears err
    drive("ld_down1",     0, 2'b00, 8'h01, 1, 0, 0, 8'h01, S_RUN,  0);
    drive("down1_done",   0, 2'b00, 8'h00, 0, 0, 1, 8'h00, S_DONE, 0);
    drive("overrun_2",    0, 2'b00, 8'h00, 0, 0, 1, 8'h00, S_DONE, ERR_EN);
    drive("idle_keeps",   0, 2'b00, 8'h00, 0, 0, 0, 8'h00, S_DONE, ERR_EN);
    drive("ld_clr_err",   0, 2'b00, 8'h07, 1, 0, 0, 8'h07, S_RUN,  0);
    // Load 0 in down mode: full 2^W block
    drive("ld_down0",     0, 2'b00, 8'h00, 1, 0, 0, 8'h00, S_RUN,  0);
    for (int i = 1; i <= 256; i++) begin
      logic [8:0] rem;
      rem = 9'(256 - i);
      drive("down_wrap", 0, 2'b00, 8'h00, 0, 0, 1, rem[7:0], (i == 256) ? S_DONE : S_RUN, 0);
    end
    // Load 0 in up mode: full 2^W block
    drive("ld_up0",       0, 2'b01, 8'h00, 1, 0, 0, 8'h00, S_RUN,  0);
    for (int i = 1; i <= 256; i++) begin
      logic [8:0] cv;
      cv = 9'(i);
      drive("up_wrap", 0, 2'b01, 8'h00, 0, 0, 1, cv[7:0], (i == 256) ? S_DONE : S_RUN, 0);
    end
    drive("final_idle",   0, 2'b01, 8'h00, 0, 0, 0, 8'h00, S_DONE, 0);

    @(negedge clk);
    cnt = 1'b0; ldwr = 1'b0; reinit = 1'b0; rst = 1'b0;
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
